// File: rtl/tff.sv
// Toggle flip-flop array: each q bit inverts on a rising clk edge when its t bit is set.
// Synchronous active-high reset loads RST_VAL and takes priority over toggling.
module tff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Next state: each bit flips independently where its toggle enable is set.
   always_comb begin
      q_d = q_q ^ t;
   end

   // State register with synchronous reset that dominates any toggle request.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_tff.sv
// Directed bench for tff: a 1-bit instance (reset value 0) and a 4-bit instance
// (reset value 4'b1010) driven from one vector table, plus between-edge corner cases.
module tb_tff;

   logic       clk;
   logic       rst;
   logic [0:0] t1;
   logic [0:0] q1;
   logic [3:0] t4;
   logic [3:0] q4;

   int total_cnt;
   int pass_cnt;

   typedef struct {
      logic       rst;
      logic [0:0] t1;
      logic [0:0] e1;
      logic [3:0] t4;
      logic [3:0] e4;
   } vec_t;

   vec_t vecs [12];

   tff #(.WIDTH(1), .RST_VAL(1'b0)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .t   (t1),
      .q   (q1)
   );

   tff #(.WIDTH(4), .RST_VAL(4'b1010)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .t   (t4),
      .q   (q4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total_cnt = total_cnt + 1;
      if (act !== exp) begin
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end else begin
         pass_cnt = pass_cnt + 1;
      end
   endtask

   initial begin
      total_cnt = 0;
      pass_cnt  = 0;

      //            rst   t1    e1    t4       e4
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'b0011, 4'b1001};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1001};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0110};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'b1000, 4'b1110};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'b0001, 4'b1111};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b0100, 4'b1011};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1011};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b1010};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 4'b0101, 4'b1111};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111};

      for (int i = 0; i < 12; i++) begin
         rst = vecs[i].rst;
         t1  = vecs[i].t1;
         t4  = vecs[i].t4;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_q1", i), {3'b000, q1}, {3'b000, vecs[i].e1});
         chk($sformatf("vec%0d_q4", i), q4, vecs[i].e4);
         @(negedge clk);
      end

      // rst pulsed between edges must not disturb q
      t1 = 1'b0;
      t4 = 4'b0000;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_pulse_mid_q1", {3'b000, q1}, 4'b0001);
      chk("rst_pulse_mid_q4", q4, 4'b1111);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_pulse_edge_q1", {3'b000, q1}, 4'b0001);
      chk("rst_pulse_edge_q4", q4, 4'b1111);

      // t raised mid-cycle: q changes only at the next edge
      @(negedge clk);
      t1 = 1'b1;
      t4 = 4'b0110;
      #1;
      chk("t_mid_q1", {3'b000, q1}, 4'b0001);
      chk("t_mid_q4", q4, 4'b1111);
      @(posedge clk);
      #1;
      chk("t_edge_q1", {3'b000, q1}, 4'b0000);
      chk("t_edge_q4", q4, 4'b1001);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
